point_check_sched: RTL and testbench
====================================

// Module: point_check_sched
// PURPOSE
//  Frame-level sequencer for the point validity checker. On start it walks vertex memory
//  addresses 0..NUM_PTS-1 and feeds each (x,y,z) plus index p and the latched wall mask to the
//  checker. Rejected results are dropped. Accepted results go through an 8-entry FIFO to the
//  projection/raster stage with a valid/ready handshake. Sits between vertex ROM and rasteriser.
// PARAMETERS
//  NUM_PTS   1000  vertices per frame, 1..1023 (p=1023 is the checker's invalid marker)
//  FIFO_DEP  8     output FIFO depth, power of 2, >=4
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   frame start pulse; ignored while busy=1
//  wall_in     in   5   wall enable mask, captured on accepted start
//  busy        out  1   high from accepted start until done
//  done        out  1   one-cycle pulse: all points checked and FIFO drained
//  rd_en       out  1   vertex memory read strobe
//  rd_addr     out  10  vertex address (= point index p)
//  rd_x/rd_y/rd_z in 12 signed vertex data, valid exactly 1 cycle after rd_en
//  chk_wall    out  5   latched mask to checker
//  chk_x/chk_y/chk_z out 12 signed registered copy of rd_* to checker
//  chk_p       out  10  index to checker
//  res_en      in   1   checker accept flag (checker latency 1 cycle)
//  res_p       in   10  checker output index
//  res_x/res_y/res_z in 10 signed checker output coords
//  out_valid   out  1   FIFO head valid
//  out_ready   in   1   downstream accepts head when out_valid & out_ready
//  out_p       out  10  head index
//  out_x/out_y/out_z out 10 signed head coords
//  valid_cnt   out  11  accepted points this frame, cleared on accepted start
// BEHAVIOUR
//  Reset: busy=0, done=0, rd_en=0, rd_addr=0, chk_*=0, chk_wall=0, out_valid=0, out_*=0,
//   valid_cnt=0, FIFO empty, in-flight=0, state IDLE. Reset mid-frame discards everything.
//  FSM: IDLE -start-> RUN (latch wall_in, addr=0, valid_cnt=0, busy=1).
//   RUN -last addr issued-> DRAIN. DRAIN -(inflight==0 & FIFO empty)-> DONE.
//   DONE -1 cycle, done=1, busy=0-> IDLE. start during RUN/DRAIN/DONE is ignored.
//  Pipeline, issue in cycle t:
//   t: rd_en=1, rd_addr=a.
//   t+1 edge: chk_x/y/z<=rd_x/y/z, chk_p<=a.
//   t+2 edge: checker registers result.
//   t+3: res_* valid. If res_en=1, push to FIFO at the t+3 edge and increment valid_cnt.
//  3-bit in-flight tag shift register marks which res_* cycles are real. res_* in untagged
//   cycles is ignored, even if res_en=1.
//  Credit rule: issue in a cycle only if fifo_count + inflight < FIFO_DEP. inflight counts
//   issued reads whose tag has not retired. The FIFO therefore never overflows and the
//   pipeline never stalls once an issue is made.
//  Rejected results (res_en=0) free their credit and do not push.
//  FIFO: first-word-fall-through. out_* equal the head entry whenever out_valid=1.
//   Simultaneous push and pop: count unchanged. Push into an empty FIFO gives out_valid=1
//   the cycle after the push edge.
//  Address increments by 1 per issue. No wrap: the last issue is NUM_PTS-1.
//  valid_cnt saturates at 2047 (unreachable for legal NUM_PTS). It holds its value after done
//   until the next start.
// TESTING
//  1) NUM_PTS=4, wall=5'b11111, all points in range, out_ready=1 -> 4 outputs, p=0..3 in order;
//     first out_valid 4 cycles after the first rd_en; done once; valid_cnt=4.
//  2) wall=5'b00001, points x=10,x=70,x=-1,y=65 -> only p=0 output; valid_cnt=1; done asserts
//     after the last tag retires.
//  3) out_ready=0, NUM_PTS=20, all valid -> exactly 8 entries held, rd_en stalls, no loss;
//     release out_ready -> remaining 12 stream out; p sequence 0..19 contiguous.
//  4) start pulsed again at cycle 5 of RUN -> ignored, p sequence and valid_cnt unaffected.
//  5) rst_n low mid-DRAIN with 3 FIFO entries -> all outputs at reset values next edge; a new
//     start gives a clean frame from p=0.
//  6) out_ready toggling 1/0 every cycle, pushes coinciding with pops -> count stays
//     consistent, no duplicates or drops (scoreboard vs. golden check model).

Source files
------------

// File: rtl/point_check_sched_if.sv
// Bus bundle between the frame sequencer, vertex memory, point checker and raster stage.
// The sequencer side uses the master modport; the surrounding environment uses slave.
interface point_check_sched_if;
  logic               rd_en;
  logic        [9:0]  rd_addr;
  logic signed [11:0] rd_x;
  logic signed [11:0] rd_y;
  logic signed [11:0] rd_z;

  logic        [4:0]  chk_wall;
  logic signed [11:0] chk_x;
  logic signed [11:0] chk_y;
  logic signed [11:0] chk_z;
  logic        [9:0]  chk_p;

  logic               res_en;
  logic        [9:0]  res_p;
  logic signed [9:0]  res_x;
  logic signed [9:0]  res_y;
  logic signed [9:0]  res_z;

  logic               out_valid;
  logic               out_ready;
  logic        [9:0]  out_p;
  logic signed [9:0]  out_x;
  logic signed [9:0]  out_y;
  logic signed [9:0]  out_z;

  modport master (
    output rd_en, rd_addr,
    input  rd_x, rd_y, rd_z,
    output chk_wall, chk_x, chk_y, chk_z, chk_p,
    input  res_en, res_p, res_x, res_y, res_z,
    output out_valid, out_p, out_x, out_y, out_z,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_x, rd_y, rd_z,
    input  chk_wall, chk_x, chk_y, chk_z, chk_p,
    output res_en, res_p, res_x, res_y, res_z,
    input  out_valid, out_p, out_x, out_y, out_z,
    output out_ready
  );
endinterface

// File: rtl/point_check_sched.sv
// Frame sequencer: streams vertices 0..NUM_PTS-1 through the point checker and queues
// accepted points in a credit-protected first-word-fall-through FIFO for the rasteriser.
module point_check_sched #(
  parameter int NUM_PTS  = 1000,
  parameter int FIFO_DEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4:0]          wall_in,
  output logic                busy,
  output logic                done,
  output logic [10:0]         valid_cnt,
  point_check_sched_if.master bus
);

  localparam int PW = $clog2(FIFO_DEP);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [9:0] LAST_ADDR = 10'(NUM_PTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic        [9:0] p;
    logic signed [9:0] x;
    logic signed [9:0] y;
    logic signed [9:0] z;
  } entry_t;

  state_t        state;
  state_t        state_nxt;
  logic [4:0]    wall_q;
  logic [9:0]    addr;
  logic [9:0]    p_d1;
  logic [2:0]    tag;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  entry_t        fifo_mem [FIFO_DEP];
  entry_t        head;
  logic [SW-1:0] committed;
  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          start_ok;

  // Every issued read owns a FIFO slot from issue until its tag retires, so the
  // pipeline never has to stall once a read is in flight.
  assign committed = SW'(count) + SW'(tag[0]) + SW'(tag[1]) + SW'(tag[2]);
  assign credit_ok = committed < SW'(FIFO_DEP);
  assign issue     = (state == RUN) && credit_ok;
  assign push      = tag[2] && bus.res_en;
  assign pop       = (count != '0) && bus.out_ready;
  assign start_ok  = (state == IDLE) && start;
  assign head      = fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && (addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((tag == 3'b000) && (count == '0)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en     = issue;
    bus.rd_addr   = addr;
    bus.chk_wall  = wall_q;
    bus.out_valid = (count != '0);
    bus.out_p     = head.p;
    bus.out_x     = head.x;
    bus.out_y     = head.y;
    bus.out_z     = head.z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // tag[k] set means the vertex issued k+1 cycles ago is real; tag[2] qualifies res_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wall_q    <= '0;
      addr      <= '0;
      p_d1      <= '0;
      tag       <= '0;
      bus.chk_x <= '0;
      bus.chk_y <= '0;
      bus.chk_z <= '0;
      bus.chk_p <= '0;
    end else begin
      tag <= {tag[1:0], issue};
      if (start_ok) begin
        wall_q <= wall_in;
        addr   <= '0;
      end else if (issue) begin
        addr <= addr + 10'd1;
        p_d1 <= addr;
      end
      if (tag[0]) begin
        bus.chk_x <= bus.rd_x;
        bus.chk_y <= bus.rd_y;
        bus.chk_z <= bus.rd_z;
        bus.chk_p <= p_d1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEP; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= entry_t'{p: bus.res_p, x: bus.res_x, y: bus.res_y, z: bus.res_z};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          valid_cnt <= '0;
    else if (start_ok)                   valid_cnt <= '0;
    else if (push && valid_cnt != 11'h7FF) valid_cnt <= valid_cnt + 11'd1;
  end

endmodule

// File: tb/tb_point_check_sched.sv
// Randomised bench for point_check_sched: vertex memory and checker models plus a
// filtered-list reference of which points must reach the output, in order.
`timescale 1ns/1ps
module tb_point_check_sched;

  localparam int NUM_PTS  = 20;
  localparam int FIFO_DEP = 8;

  typedef struct {
    int p;
    int x;
    int y;
    int z;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  wall_in = '0;
  logic        busy;
  logic        done;
  logic [10:0] valid_cnt;

  point_check_sched_if bus();

  point_check_sched #(.NUM_PTS(NUM_PTS), .FIFO_DEP(FIFO_DEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wall_in(wall_in),
    .busy(busy), .done(done), .valid_cnt(valid_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  logic signed [11:0] mem_x [NUM_PTS];
  logic signed [11:0] mem_y [NUM_PTS];
  logic signed [11:0] mem_z [NUM_PTS];
  exp_t exp_q [$];
  exp_t mon_e;
  int   exp_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rd_cnt, first_rd, first_ov, last_rd, done_cyc, done_cnt;

  // Checker rule owned by the bench: each wall bit enables one constraint.
  function automatic bit accept(input int x, input int y, input int z, input logic [4:0] w);
    bit ok = 1'b1;
    if (w[0] && (x < 0 || x > 63 || y < 0 || y > 63)) ok = 1'b0;
    if (w[1] && (z < 0 || z > 63)) ok = 1'b0;
    if (w[2] && (x + y > 100)) ok = 1'b0;
    if (w[3] && (z < x)) ok = 1'b0;
    if (w[4] && (z > 500 || z < -500)) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_x <= mem_x[bus.rd_addr];
      bus.rd_y <= mem_y[bus.rd_addr];
      bus.rd_z <= mem_z[bus.rd_addr];
    end else begin
      bus.rd_x <= 12'($urandom);
      bus.rd_y <= 12'($urandom);
      bus.rd_z <= 12'($urandom);
    end
  end

  always @(posedge clk) begin
    bus.res_en <= accept(int'(bus.chk_x), int'(bus.chk_y), int'(bus.chk_z), bus.chk_wall);
    bus.res_p  <= bus.chk_p;
    bus.res_x  <= bus.chk_x[9:0];
    bus.res_y  <= bus.chk_y[9:0];
    bus.res_z  <= bus.chk_z[9:0];
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.rd_en) begin
        rd_cnt++;
        last_rd = cyc;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_out_p", bus.out_p, -1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_p", bus.out_p, mon_e.p);
          checkOutput("out_x", bus.out_x, mon_e.x);
          checkOutput("out_y", bus.out_y, mon_e.y);
          checkOutput("out_z", bus.out_z, mon_e.z);
        end
      end
    end
  end

  // mode 0: all in range, 1: random, 2: fixed reject pattern, 3: only p=2,7,11 valid
  task automatic applyStimulus(input int mode, input logic [4:0] wall);
    int x, y, z;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < NUM_PTS; i++) begin
      x = 5; y = 5; z = 5;
      case (mode)
        0: begin
          x = int'($urandom_range(0, 50));
          y = int'($urandom_range(0, 50));
          z = int'($urandom_range(x, 63));
        end
        1: begin
          x = int'($urandom_range(0, 160)) - 40;
          y = int'($urandom_range(0, 160)) - 40;
          z = int'($urandom_range(0, 160)) - 40;
        end
        2: begin
          case (i)
            0:       x = 10;
            1:       x = 70;
            2:       x = -1;
            3:       y = 65;
            default: x = 100;
          endcase
        end
        default: if (i != 2 && i != 7 && i != 11) x = 100;
      endcase
      mem_x[i] = 12'(x);
      mem_y[i] = 12'(y);
      mem_z[i] = 12'(z);
      if (accept(x, y, z, wall)) begin
        exp_q.push_back('{p: i, x: x, y: y, z: z});
        exp_cnt++;
      end
    end
    @(posedge clk); #1;
    rd_cnt = 0; first_rd = -1; first_ov = -1; last_rd = -1; done_cyc = -1; done_cnt = 0;
    wall_in = wall;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wall_in = 5'($urandom);
  endtask

  // ready mode 0: hold, 1: toggle every cycle, 2: random
  task automatic waitDone(input int rmode, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      case (rmode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom);
        default: ;
      endcase
      k++;
    end
    if (done_cnt == 0) checkOutput("done_timeout", 0, 1);
    bus.out_ready = 1'b1;
  endtask

  task automatic finishFrame();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_cnt, 1);
    checkOutput("valid_cnt", valid_cnt, exp_cnt);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("missing_outputs", exp_q.size(), 0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_en", bus.rd_en, 0);
    checkOutput("rst_rd_addr", bus.rd_addr, 0);
    checkOutput("rst_chk_p", bus.chk_p, 0);
    checkOutput("rst_chk_x", bus.chk_x, 0);
    checkOutput("rst_chk_y", bus.chk_y, 0);
    checkOutput("rst_chk_z", bus.chk_z, 0);
    checkOutput("rst_chk_wall", bus.chk_wall, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_p", bus.out_p, 0);
    checkOutput("rst_out_x", bus.out_x, 0);
    checkOutput("rst_valid_cnt", valid_cnt, 0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    rd_cnt = 0; first_rd = -1; first_ov = -1; last_rd = -1; done_cyc = -1; done_cnt = 0;
    repeat (2) @(negedge clk);
    checkResetState();
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] frame with all points valid");
    bus.out_ready = 1'b1;
    applyStimulus(0, 5'b11111);
    waitDone(0, 400);
    checkOutput("t1_first_latency", first_ov - first_rd, 4);
    checkOutput("t1_rd_count", rd_cnt, NUM_PTS);
    finishFrame();

    $display("[TB] frame with fixed reject pattern");
    applyStimulus(2, 5'b00001);
    waitDone(0, 400);
    checkOutput("t2_done_gap", done_cyc - last_rd, 5);
    checkOutput("t2_valid_cnt", valid_cnt, 1);
    finishFrame();

    $display("[TB] frame against a stalled output");
    bus.out_ready = 1'b0;
    applyStimulus(0, 5'b11111);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("t3_stall_rd_cnt", rd_cnt, FIFO_DEP);
    checkOutput("t3_stall_valid", bus.out_valid, 1);
    checkOutput("t3_stall_head_p", bus.out_p, 0);
    checkOutput("t3_stall_valid_cnt", valid_cnt, FIFO_DEP);
    bus.out_ready = 1'b1;
    waitDone(0, 400);
    finishFrame();

    $display("[TB] frame with a second start while running");
    applyStimulus(1, 5'b00011);
    repeat (4) @(posedge clk);
    #1;
    start   = 1'b1;
    wall_in = 5'b00000;
    @(posedge clk); #1;
    start   = 1'b0;
    waitDone(0, 400);
    finishFrame();

    $display("[TB] reset while draining");
    bus.out_ready = 1'b0;
    applyStimulus(3, 5'b00001);
    for (int k = 0; k < 200 && rd_cnt < NUM_PTS; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5_all_issued", rd_cnt, NUM_PTS);
    checkOutput("t5_busy_drain", busy, 1);
    checkOutput("t5_valid_cnt", valid_cnt, 3);
    checkOutput("t5_head_p", bus.out_p, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    checkResetState();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1, 5'($urandom));
    waitDone(2, 600);
    finishFrame();

    $display("[TB] frames with toggling ready");
    applyStimulus(0, 5'b11111);
    waitDone(1, 600);
    finishFrame();
    applyStimulus(1, 5'($urandom));
    waitDone(1, 600);
    finishFrame();

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      applyStimulus(f[0] ? 1 : 0, f[0] ? 5'($urandom) : 5'b11111);
      waitDone(2, 800);
      finishFrame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
